fifo_uart_tx: RTL and testbench

Drain side of the 8-deep byte FIFO. Pops bytes through the FIFO read/ready interface and sends each one as an asynchronous serial frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Sits between the FIFO data_out/ready/read pins and the chip-level serial TX pad.

---
 rtl/fifo_uart_tx_pkg.sv | 21 ++
 rtl/fifo_uart_baud_tick.sv | 30 +++
 rtl/fifo_uart_tx.sv | 127 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;

  localparam logic        TX_IDLE_LEVEL = 1'b1;
  localparam int unsigned DATA_BITS     = 8;

  // Baud counter width; never below 1 so the counter stays a real register.
  function automatic int unsigned baud_cnt_width(input int unsigned clks_per_bit);
    return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
  endfunction

endpackage

// File: rtl/fifo_uart_baud_tick.sv
// Bit-period counter: flags the last cycle and the second-to-last cycle of each bit.
module fifo_uart_baud_tick
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clrn,
  input  logic clear,
  input  logic run,
  output logic bit_end,
  output logic bit_near
);

  localparam int unsigned W    = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] NEAR = W'(CLKS_PER_BIT - 2);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)           cnt <= '0;
    else if (clear)      cnt <= '0;
    else if (run)        cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
  end

  assign bit_end  = run && (cnt == LAST);
  assign bit_near = run && (cnt == NEAR);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the 8-deep FIFO and serialises each as start/data/[parity]/stop.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       enable,
  input  logic       fifo_ready,
  input  logic [7:0] fifo_data,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  state_t                 state;
  logic [DATA_BITS-1:0]   shift;
  logic [2:0]             bit_idx;
  logic                   parity;
  logic                   baud_clear;
  logic                   baud_run;
  logic                   bit_end;
  logic                   bit_near;

  assign baud_clear = (state == LOAD);
  assign baud_run   = (state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP);

  fifo_uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .clrn     (clrn),
    .clear    (baud_clear),
    .run      (baud_run),
    .bit_end  (bit_end),
    .bit_near (bit_near)
  );

  // tx is registered, so each state loads the level the next state must show.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= IDLE;
      tx         <= TX_IDLE_LEVEL;
      fifo_read  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      shift      <= '0;
      bit_idx    <= '0;
      parity     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= TX_IDLE_LEVEL;
          if (enable && fifo_ready && !fifo_read) begin
            fifo_read <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          shift     <= fifo_data;
          fifo_read <= 1'b0;
          parity    <= 1'b0;
          bit_idx   <= '0;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_end) begin
            tx    <= shift[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            parity <= parity ^ shift[0];
            shift  <= shift >> 1;
            if (bit_idx == LAST_DATA) begin
              bit_idx <= '0;
              if (PARITY_EN) begin
                tx    <= parity ^ shift[0] ^ PARITY_ODD;
                state <= PARITY;
              end else begin
                tx    <= TX_IDLE_LEVEL;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            tx    <= TX_IDLE_LEVEL;
            state <= STOP;
          end
        end
        STOP: begin
          // Raised one cycle early so the registered pulse lands on the final stop cycle.
          if (bit_near && (bit_idx == LAST_STOP)) frame_done <= 1'b1;
          if (bit_end) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and hand-derived frames.
module tb_fifo_uart_tx;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  logic enable = 1'b0;

  // Main DUT: CLKS_PER_BIT=4, no parity, 1 stop bit, fed from a FIFO model.
  logic [7:0]  fifo_mem [0:15];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned pop_cnt = 0;
  logic        fifo_ready;
  logic [7:0]  fifo_data;
  logic        fifo_read, tx, busy, frame_done;

  assign fifo_ready = (wr_ptr != rd_ptr);
  assign fifo_data  = fifo_mem[rd_ptr % 16];

  // Parity DUTs: even and odd, 2 stop bits, each fed a single constant byte 0x07.
  int unsigned pe_req = 0, pe_done = 0, po_req = 0, po_done = 0;
  logic pe_ready, pe_read, pe_tx, pe_busy, pe_fd;
  logic po_ready, po_read, po_tx, po_busy, po_fd;
  assign pe_ready = (pe_req != pe_done);
  assign po_ready = (po_req != po_done);

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  logic prev_read = 1'b0;

  logic tx_rec [0:127];
  logic fd_rec [0:127];

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut (
    .clk(clk), .clrn(clrn), .enable(enable), .fifo_ready(fifo_ready), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_pe (
    .clk(clk), .clrn(clrn), .enable(1'b1), .fifo_ready(pe_ready), .fifo_data(8'h07),
    .fifo_read(pe_read), .tx(pe_tx), .busy(pe_busy), .frame_done(pe_fd));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut_po (
    .clk(clk), .clrn(clrn), .enable(1'b1), .fifo_ready(po_ready), .fifo_data(8'h07),
    .fifo_read(po_read), .tx(po_tx), .busy(po_busy), .frame_done(po_fd));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_read) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (pe_read) pe_done <= pe_done + 1;
    if (po_read) po_done <= po_done + 1;
  end

  always @(negedge clk) begin
    if (fifo_read && (!fifo_ready || prev_read)) viol <= viol + 1;
    prev_read <= fifo_read;
  end

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok, output int fd_seen);
    ok = 1'b0;
    fd_seen = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_seen++;
      if (busy === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      tx_rec[i] = tx;
      fd_rec[i] = frame_done;
    end
  endtask

  task automatic test_reset;
    bit bad, ok;
    int fdc;
    clrn = 1'b0;
    enable = 1'b1;
    push(8'h3C);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_read !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL reset_hold tx=%b fifo_read=%b busy=%b want 1,0,0", tx, fifo_read, busy);
    end
    clrn = 1'b1;
    @(negedge clk);
    tests++;
    if (fifo_read !== 1'b1) begin
      fails++;
      $display("FAIL reset_first_pop fifo_read=%b want 1", fifo_read);
    end
    wait_idle(ok, fdc);
    tests++;
    if (!ok || pop_cnt !== 1) begin
      fails++;
      $display("FAIL reset_frame idle=%0d pops=%0d want 1,1", ok, pop_cnt);
    end
  endtask

  task automatic test_single_byte;
    logic [0:9] exp_a5;
    bit bad;
    int fdc;
    int unsigned p0;
    exp_a5 = 10'b0101001011;
    p0 = pop_cnt;
    push(8'hA5);
    @(negedge clk);
    tests++;
    if (fifo_read !== 1'b1) begin
      fails++;
      $display("FAIL single_pop_hi fifo_read=%b want 1", fifo_read);
    end
    @(negedge clk);
    tests++;
    if (fifo_read !== 1'b0 || tx !== 1'b0) begin
      fails++;
      $display("FAIL single_pop_lo fifo_read=%b tx=%b want 0,0", fifo_read, tx);
    end
    record(40);
    for (int b = 0; b < 10; b++) begin
      bad = 1'b0;
      for (int k = 0; k < 4; k++) if (tx_rec[4*b+k] !== exp_a5[b]) bad = 1'b1;
      tests++;
      if (bad) begin
        fails++;
        $display("FAIL single_bit%0d got %b%b%b%b want %b", b,
                 tx_rec[4*b], tx_rec[4*b+1], tx_rec[4*b+2], tx_rec[4*b+3], exp_a5[b]);
      end
    end
    fdc = 0;
    for (int i = 0; i < 40; i++) if (fd_rec[i] === 1'b1) fdc++;
    tests++;
    if (fdc != 1 || fd_rec[39] !== 1'b1) begin
      fails++;
      $display("FAIL single_frame_done pulses=%0d at39=%b want 1,1", fdc, fd_rec[39]);
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || pop_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL single_after tx=%b busy=%b fd=%b pops=%0d want 1,0,0,1",
               tx, busy, frame_done, pop_cnt - p0);
    end
  endtask

  task automatic test_back_to_back;
    bit found, bad, ok;
    int fdc;
    int unsigned p0;
    p0 = pop_cnt;
    push(8'h00);
    push(8'hFF);
    wait_start(found);
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL b2b_start timeout tx=%b want 0", tx);
    end
    record(82);
    bad = 1'b0;
    for (int i = 4; i < 36; i++) if (tx_rec[i] !== 1'b0) bad = 1'b1;
    for (int i = 36; i < 40; i++) if (tx_rec[i] !== 1'b1) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL b2b_first_frame data/stop levels wrong, want 32x0 then 4x1");
    end
    tests++;
    if (tx_rec[40] !== 1'b1 || tx_rec[41] !== 1'b1 || tx_rec[42] !== 1'b0) begin
      fails++;
      $display("FAIL b2b_gap got %b%b%b want 110", tx_rec[40], tx_rec[41], tx_rec[42]);
    end
    bad = 1'b0;
    for (int i = 46; i < 82; i++) if (tx_rec[i] !== 1'b1) bad = 1'b1;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL b2b_second_frame data/stop not all 1");
    end
    wait_idle(ok, fdc);
    tests++;
    if (!ok || pop_cnt - p0 !== 2) begin
      fails++;
      $display("FAIL b2b_pops idle=%0d pops=%0d want 1,2", ok, pop_cnt - p0);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL empty_idle tx=%b busy=%b fifo_read=%b want 1,0,0", tx, busy, fifo_read);
    end
  endtask

  task automatic test_parity;
    logic [0:11] exp_pe, exp_po;
    logic pe_rec [0:47];
    logic po_rec [0:47];
    logic pf_rec [0:47];
    logic of_rec [0:47];
    bit found, bad_pe, bad_po;
    int fpe, fpo;
    exp_pe = 12'b011100000111;
    exp_po = 12'b011100000011;
    pe_req = pe_req + 1;
    po_req = po_req + 1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (pe_tx === 1'b0) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL parity_start timeout pe_tx=%b want 0", pe_tx);
    end
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      pe_rec[i] = pe_tx;
      po_rec[i] = po_tx;
      pf_rec[i] = pe_fd;
      of_rec[i] = po_fd;
    end
    for (int b = 0; b < 12; b++) begin
      bad_pe = 1'b0;
      bad_po = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (pe_rec[4*b+k] !== exp_pe[b]) bad_pe = 1'b1;
        if (po_rec[4*b+k] !== exp_po[b]) bad_po = 1'b1;
      end
      tests++;
      if (bad_pe || bad_po) begin
        fails++;
        $display("FAIL parity_bit%0d even=%b odd=%b want %b,%b", b,
                 pe_rec[4*b+1], po_rec[4*b+1], exp_pe[b], exp_po[b]);
      end
    end
    fpe = 0;
    fpo = 0;
    for (int i = 0; i < 48; i++) begin
      if (pf_rec[i] === 1'b1) fpe++;
      if (of_rec[i] === 1'b1) fpo++;
    end
    tests++;
    if (fpe != 1 || fpo != 1 || pf_rec[47] !== 1'b1 || of_rec[47] !== 1'b1) begin
      fails++;
      $display("FAIL parity_frame_done pulses=%0d/%0d at47=%b/%b want 1/1,1/1",
               fpe, fpo, pf_rec[47], of_rec[47]);
    end
    @(negedge clk);
    tests++;
    if (pe_busy !== 1'b0 || po_busy !== 1'b0 || pe_tx !== 1'b1) begin
      fails++;
      $display("FAIL parity_len busy=%b/%b tx=%b want 0/0,1", pe_busy, po_busy, pe_tx);
    end
  endtask

  task automatic test_enable_drop;
    bit found, ok, bad;
    int fdc;
    int unsigned p0, p1;
    logic [7:0] got;
    p0 = pop_cnt;
    push(8'h5A);
    wait_start(found);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    push(8'h81);
    wait_idle(ok, fdc);
    tests++;
    if (!found || !ok || fdc != 1 || pop_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL endrop_finish start=%0d idle=%0d fd=%0d pops=%0d want 1,1,1,1",
               found, ok, fdc, pop_cnt - p0);
    end
    p1 = pop_cnt;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_read !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad = 1'b1;
    end
    tests++;
    if (bad || pop_cnt !== p1) begin
      fails++;
      $display("FAIL endrop_hold fifo_read=%b busy=%b pops=%0d want 0,0,0", fifo_read, busy, pop_cnt - p1);
    end
    enable = 1'b1;
    @(negedge clk);
    tests++;
    if (fifo_read !== 1'b1) begin
      fails++;
      $display("FAIL endrop_repop fifo_read=%b want 1", fifo_read);
    end
    @(negedge clk);
    tests++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL endrop_restart tx=%b busy=%b want 0,1", tx, busy);
    end
    record(40);
    for (int b = 0; b < 8; b++) got[b] = tx_rec[4 + 4*b + 2];
    tests++;
    if (got !== 8'h81) begin
      fails++;
      $display("FAIL endrop_byte got %h want 81", got);
    end
    wait_idle(ok, fdc);
  endtask

  task automatic test_reset_mid;
    bit found, ok, bad;
    int fdc;
    int unsigned p0;
    logic [7:0] got;
    p0 = pop_cnt;
    push(8'h12);
    push(8'h34);
    wait_start(found);
    repeat (17) @(negedge clk);
    tests++;
    if (!found || tx !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_bit3 start=%0d tx=%b want 1,0", found, tx);
    end
    clrn = 1'b0;
    #1;
    tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async tx=%b busy=%b fifo_read=%b want 1,0,0", tx, busy, fifo_read);
    end
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_read !== 1'b0) bad = 1'b1;
    end
    tests++;
    if (bad || pop_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL rstmid_hold tx=%b pops=%0d want 1,1", tx, pop_cnt - p0);
    end
    clrn = 1'b1;
    @(negedge clk);
    tests++;
    if (fifo_read !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_repop fifo_read=%b want 1", fifo_read);
    end
    @(negedge clk);
    record(40);
    for (int b = 0; b < 8; b++) got[b] = tx_rec[4 + 4*b + 2];
    tests++;
    if (tx_rec[0] !== 1'b0 || got !== 8'h34) begin
      fails++;
      $display("FAIL rstmid_next_byte start=%b got %h want 0,34", tx_rec[0], got);
    end
    wait_idle(ok, fdc);
    tests++;
    if (!ok || pop_cnt - p0 !== 2) begin
      fails++;
      $display("FAIL rstmid_pops idle=%0d pops=%0d want 1,2", ok, pop_cnt - p0);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_parity;
    test_enable_drop;
    test_reset_mid;
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL pop_protocol violations=%0d want 0", viol);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
